// File: rtl/flag_ctrl_if.sv
// Bundle of ALU-flag, stack-control, condition and status signals for flag_ctrl.
// The slave modport is the controller's view; master is the driver's view.
interface flag_ctrl_if #(
  parameter int PW = 2
);
  logic          Z_in, C_in, N_in, O_in;
  logic [3:0]    upd_mask;
  logic          push;
  logic          pop;
  logic [3:0]    cond;
  logic          err_clr;
  logic          Z, C, N, O;
  logic          cond_true;
  logic [PW:0]   depth;
  logic          full, empty;
  logic          ovf_err, unf_err;

  modport master (
    output Z_in, C_in, N_in, O_in, upd_mask, push, pop, cond, err_clr,
    input  Z, C, N, O, cond_true, depth, full, empty, ovf_err, unf_err
  );

  modport slave (
    input  Z_in, C_in, N_in, O_in, upd_mask, push, pop, cond, err_clr,
    output Z, C, N, O, cond_true, depth, full, empty, ovf_err, unf_err
  );
endinterface

// File: rtl/flag_ctrl.sv
// Z/C/N/O status flag controller: per-flag write enables, a save/restore
// stack for exception entry/return, and branch condition evaluation.
module flag_ctrl #(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        asyn_n_rst,
  flag_ctrl_if.slave  bus
);

  typedef enum logic [3:0] {
    CC_EQ, CC_NE, CC_CS, CC_CC, CC_MI, CC_PL, CC_VS, CC_VC,
    CC_HI, CC_LS, CC_GE, CC_LT, CC_GT, CC_LE, CC_AL, CC_NV
  } cond_e;

  localparam logic [PW:0] FULL_LVL = DEPTH[PW:0];
  localparam logic [PW:0] ONE      = {{PW{1'b0}}, 1'b1};

  // Flags are packed {Z,C,N,O} everywhere, matching upd_mask bit order.
  logic [3:0]  flags_q, flags_d;
  logic [3:0]  stack_q [DEPTH];
  logic [PW:0] depth_q;
  logic [PW:0] depth_m1;
  logic        ovf_q, unf_q;

  logic        full, empty;
  logic        push_ok, pop_ok;
  logic        ovf_set, unf_set;
  logic [3:0]  flags_in;

  assign full     = (depth_q == FULL_LVL);
  assign empty    = (depth_q == '0);
  assign depth_m1 = depth_q - ONE;
  assign flags_in = {bus.Z_in, bus.C_in, bus.N_in, bus.O_in};

  // Simultaneous push and pop is treated as a no-op for the stack.
  assign push_ok = bus.push & ~bus.pop & ~full;
  assign pop_ok  = bus.pop  & ~bus.push & ~empty;
  assign ovf_set = bus.push & ~bus.pop & full;
  assign unf_set = bus.pop  & ~bus.push & empty;

  // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latch).
  always_comb begin
    flags_d = (flags_in & bus.upd_mask) | (flags_q & ~bus.upd_mask);
    if (pop_ok) flags_d = stack_q[depth_m1[PW-1:0]];
  end

  // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge clk or negedge asyn_n_rst) begin
    if (!asyn_n_rst) begin
      flags_q <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      if (push_ok)     depth_q <= depth_q + ONE;
      else if (pop_ok) depth_q <= depth_m1;
      // A same-cycle error outranks the clear.
      ovf_q <= ovf_set | (ovf_q & ~bus.err_clr);
      unf_q <= unf_set | (unf_q & ~bus.err_clr);
    end
  end

  // NOTE: the stack is a handful of flops, so it is reset like any other register rather than left as uninitialised memory.
  always_ff @(posedge clk or negedge asyn_n_rst) begin
    if (!asyn_n_rst) begin
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
    end else if (push_ok) begin
      stack_q[depth_q[PW-1:0]] <= flags_q;
    end
  end

  always_comb begin
    bus.cond_true = 1'b0;
    unique case (cond_e'(bus.cond))
      CC_EQ: bus.cond_true =  flags_q[3];
      CC_NE: bus.cond_true = ~flags_q[3];
      CC_CS: bus.cond_true =  flags_q[2];
      CC_CC: bus.cond_true = ~flags_q[2];
      CC_MI: bus.cond_true =  flags_q[1];
      CC_PL: bus.cond_true = ~flags_q[1];
      CC_VS: bus.cond_true =  flags_q[0];
      CC_VC: bus.cond_true = ~flags_q[0];
      CC_HI: bus.cond_true =  flags_q[2] & ~flags_q[3];
      CC_LS: bus.cond_true = ~flags_q[2] |  flags_q[3];
      CC_GE: bus.cond_true = (flags_q[1] == flags_q[0]);
      CC_LT: bus.cond_true = (flags_q[1] != flags_q[0]);
      CC_GT: bus.cond_true = ~flags_q[3] & (flags_q[1] == flags_q[0]);
      CC_LE: bus.cond_true =  flags_q[3] | (flags_q[1] != flags_q[0]);
      CC_AL: bus.cond_true = 1'b1;
      CC_NV: bus.cond_true = 1'b0;
      default: bus.cond_true = 1'b0;
    endcase
  end

  assign {bus.Z, bus.C, bus.N, bus.O} = flags_q;
  assign bus.depth   = depth_q;
  assign bus.full    = full;
  assign bus.empty   = empty;
  assign bus.ovf_err = ovf_q;
  assign bus.unf_err = unf_q;

endmodule

// File: tb/tb_flag_ctrl.sv
// Self-checking bench for flag_ctrl: a queue-based reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_flag_ctrl;

  localparam int DEPTH = 4;
  localparam int PW    = 2;

  logic clk = 1'b0;
  logic asyn_n_rst = 1'b0;

  flag_ctrl_if #(.PW(PW)) bus ();

  flag_ctrl #(.DEPTH(DEPTH), .PW(PW)) dut (
    .clk        (clk),
    .asyn_n_rst (asyn_n_rst),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [3:0] m_flags = '0;
  logic [3:0] m_stack [$];
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;

  // Conditions come in complementary pairs; evaluate the even member, flip on odd.
  function automatic logic model_cond(input logic [3:0] c, input logic [3:0] f);
    logic z, cy, n, o, base;
    {z, cy, n, o} = f;
    case (c >> 1)
      0: base = z;
      1: base = cy;
      2: base = n;
      3: base = o;
      4: base = cy && !z;
      5: base = (n == o);
      6: base = !z && (n == o);
      default: base = 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  always @(posedge clk or negedge asyn_n_rst) begin
    if (!asyn_n_rst) begin
      m_flags = '0;
      m_stack.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      logic [3:0] fin;
      logic       do_pop;
      fin    = {bus.Z_in, bus.C_in, bus.N_in, bus.O_in};
      do_pop = 1'b0;
      if (bus.err_clr) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
      if (bus.push && !bus.pop) begin
        if (m_stack.size() < DEPTH) m_stack.push_back(m_flags);
        else m_ovf = 1'b1;
      end
      if (bus.pop && !bus.push) begin
        if (m_stack.size() > 0) do_pop = 1'b1;
        else m_unf = 1'b1;
      end
      if (do_pop) m_flags = m_stack.pop_back();
      else begin
        for (int b = 0; b < 4; b++)
          if (bus.upd_mask[b]) m_flags[b] = fin[b];
      end
    end
  end

  always @(negedge clk) begin
    if (asyn_n_rst) begin
      logic [31:0] act, exp;
      int sz;
      sz  = m_stack.size();
      act = {19'd0, bus.Z, bus.C, bus.N, bus.O, bus.cond_true, bus.depth,
             bus.full, bus.empty, bus.ovf_err, bus.unf_err};
      exp = {19'd0, m_flags, model_cond(bus.cond, m_flags), sz[PW:0],
             (sz == DEPTH), (sz == 0), m_ovf, m_unf};
      check("model", act, exp);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic [3:0] fin, input logic [3:0] m,
                     input logic pu, input logic po, input logic clr);
    {bus.Z_in, bus.C_in, bus.N_in, bus.O_in} = fin;
    bus.upd_mask = m;
    bus.push     = pu;
    bus.pop      = po;
    bus.err_clr  = clr;
    tick();
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.err_clr = 1'b0;
  endtask

  function automatic logic [3:0] flags();
    return {bus.Z, bus.C, bus.N, bus.O};
  endfunction

  logic [15:0] sweep_exp [4] = '{16'h56AA, 16'h6996, 16'h66A9, 16'h565A};
  logic [3:0]  sweep_flg [4] = '{4'b0000, 4'b0110, 4'b1000, 4'b0011};

  initial begin
    {bus.Z_in, bus.C_in, bus.N_in, bus.O_in} = 4'b0000;
    bus.upd_mask = '0;
    bus.push     = 1'b0;
    bus.pop      = 1'b0;
    bus.cond     = 4'd14;
    bus.err_clr  = 1'b0;
    #23;
    check("reset_flags", {28'd0, flags()}, 32'h0);
    check("reset_empty", {31'd0, bus.empty}, 32'd1);
    asyn_n_rst = 1'b1;
    tick();
    check("reset_depth", {29'd0, bus.depth}, 32'd0);

    // masked update then hold
    cyc(4'b1111, 4'b1010, 0, 0, 0);
    check("mask_1010", {28'd0, flags()}, 32'hA);
    cyc(4'b0000, 4'b0000, 0, 0, 0);
    check("mask_hold", {28'd0, flags()}, 32'hA);

    // nested save/restore
    cyc(4'b1000, 4'b1111, 0, 0, 0);
    cyc(4'b0110, 4'b1111, 1, 0, 0);
    cyc(4'b0000, 4'b0000, 1, 0, 0);
    check("nest_depth2", {29'd0, bus.depth}, 32'd2);
    cyc(4'b0000, 4'b1111, 0, 1, 0);
    check("nest_pop1", {28'd0, flags(), 29'd0, bus.depth} >> 0, {28'd0, 4'b0110, 29'd0, 3'd1});
    cyc(4'b0000, 4'b0000, 0, 1, 0);
    check("nest_pop2", {28'd0, flags()}, 32'h8);
    check("nest_empty", {31'd0, bus.empty}, 32'd1);

    // overflow: saved entries 1000,0001,0010,0011; fifth push overflows
    for (int i = 1; i <= 5; i++) cyc(i[3:0], 4'b1111, 1, 0, 0);
    check("ovf_state", {28'd0, bus.depth, bus.full, bus.ovf_err},
          {28'd0, 3'd4, 1'b1, 1'b1});
    check("ovf_flags", {28'd0, flags()}, 32'h5);
    cyc(4'b0000, 4'b0000, 0, 1, 0);
    check("stack_top", {28'd0, flags()}, 32'h3);
    for (int i = 0; i < 4; i++) cyc(4'b0000, 4'b0000, 0, 1, 0);
    check("unf_state", {28'd0, bus.depth, bus.unf_err, bus.ovf_err},
          {28'd0, 3'd0, 1'b1, 1'b1});
    check("unf_flags", {28'd0, flags()}, 32'h8);
    cyc(4'b0000, 4'b0000, 0, 0, 1);
    check("err_clr", {30'd0, bus.ovf_err, bus.unf_err}, 32'd0);

    // simultaneous push+pop at depth 2
    cyc(4'b0000, 4'b0000, 1, 0, 0);
    cyc(4'b0000, 4'b0000, 1, 0, 0);
    cyc(4'b0001, 4'b1111, 1, 1, 0);
    check("pushpop", {24'd0, flags(), bus.depth, bus.ovf_err, bus.unf_err},
          {24'd0, 4'b0001, 3'd2, 1'b0, 1'b0});

    // error detected in the same cycle as err_clr stays set
    cyc(4'b0000, 4'b0000, 0, 1, 0);
    cyc(4'b0000, 4'b0000, 0, 1, 0);
    cyc(4'b0000, 4'b0000, 0, 1, 1);
    check("err_wins", {31'd0, bus.unf_err}, 32'd1);
    cyc(4'b0000, 4'b0000, 0, 0, 1);

    // condition sweep
    for (int k = 0; k < 4; k++) begin
      cyc(sweep_flg[k], 4'b1111, 0, 0, 0);
      for (int c = 0; c < 16; c++) begin
        bus.cond = c[3:0];
        tick();
        check($sformatf("cond_f%0h_c%0d", sweep_flg[k], c),
              {31'd0, bus.cond_true}, {31'd0, sweep_exp[k][c]});
      end
    end

    // cond_true does not see same-cycle inputs
    bus.cond = 4'd0;
    {bus.Z_in, bus.C_in, bus.N_in, bus.O_in} = 4'b1000;
    bus.upd_mask = 4'b1111;
    #1;
    check("no_bypass", {31'd0, bus.cond_true}, 32'd0);
    tick();
    check("cond_after_edge", {31'd0, bus.cond_true}, 32'd1);
    bus.upd_mask = 4'b0000;

    // reset mid-operation
    cyc(4'b1111, 4'b1111, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(4'b1111, 4'b1111, 1, 0, 0);
    check("pre_rst", {24'd0, flags(), bus.depth, bus.empty},
          {24'd0, 4'b1111, 3'd3, 1'b0});
    #1 asyn_n_rst = 1'b0;
    #1;
    check("mid_rst", {24'd0, flags(), bus.depth, bus.empty},
          {24'd0, 4'b0000, 3'd0, 1'b1});
    #1 asyn_n_rst = 1'b1;
    cyc(4'b0000, 4'b0000, 0, 1, 0);
    check("rst_unf", {28'd0, bus.depth, bus.unf_err}, {28'd0, 3'd0, 1'b1});
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flag_ctrl.md
# flag_ctrl

Controller for the processor's Z/C/N/O status flags. It replaces the unconditional every-cycle flag capture with per-flag write enables. It adds a DEPTH-entry save/restore stack so exception/interrupt entry and return can preserve flags. It also evaluates a 4-bit branch condition code against the held flags. It sits between the ALU flag outputs and the branch/PC-select logic, and is driven by the main decoder and the exception sequencer.

## Interface
Parameters:
- DEPTH, 4, number of flag save-stack entries (power of two, ≥2)
- PW, $clog2(DEPTH), stack pointer width

Ports:
- clk  input  1  rising-edge clock
- asyn_n_rst  input  1  asynchronous active-low reset
- Z_in, C_in, N_in, O_in  input  1 each  ALU flags of current instruction
- upd_mask  input  4  per-flag write enable, bit3=Z, bit2=C, bit1=N, bit0=O
- push  input  1  save current held flags onto stack
- pop  input  1  restore flags from stack top
- cond  input  4  condition code to evaluate
- err_clr  input  1  clear sticky error bits
- Z, C, N, O  output  1 each  held flags
- cond_true  output  1  combinational result of cond on held flags
- depth  output  PW+1  number of occupied stack entries
- full, empty  output  1 each  depth==DEPTH / depth==0
- ovf_err, unf_err  output  1 each  sticky push-when-full / pop-when-empty

## Operation
- Reset: Z=C=N=O=0, depth=0, empty=1, full=0, ovf_err=unf_err=0, all stack entries 0.
- Normal cycle (no valid pop): each held flag loads its *_in when its upd_mask bit is 1, else holds.
- Valid push (push=1, pop=0, !full):
  - stack[depth] <= pre-edge held {Z,C,N,O}; depth+1.
  - Flag update per upd_mask proceeds in the same cycle.
- Valid pop (pop=1, push=0, !empty):
  - {Z,C,N,O} <= stack[depth-1]; depth-1.
  - upd_mask is ignored this cycle; restore wins.
- push=1 when full: stack unchanged, ovf_err<=1, flags update per mask.
- pop=1 when empty: stack unchanged, unf_err<=1, flags update per mask.
- push=1 and pop=1 together: illegal; stack and depth unchanged, neither error set, flags update per mask.
- err_clr=1 clears both sticky bits. An error detected in the same cycle wins, so the bit stays 1.
- Condition codes, evaluated on held (registered) flags:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS O; 7 VC !O
  - 8 HI C&!Z; 9 LS !C|Z; 10 GE N==O; 11 LT N!=O
  - 12 GT !Z&(N==O); 13 LE Z|(N!=O); 14 AL 1; 15 NV 0

## Timing
- Flags, stack, depth and errors are all registered on the rising edge of clk. Reset acts on the asynchronous falling edge of asyn_n_rst.
- Flag write latency is 1 cycle: flags written at edge k are visible on Z/C/N/O and cond_true after edge k.
- cond_true is purely combinational from cond and the held flags. It does not see Z_in..O_in of the same cycle (no bypass).
- full/empty are decoded from registered depth and valid in the same cycle as depth.
- Back-to-back push/pop on consecutive cycles is supported at full rate. depth moves by at most 1 per cycle.
- Reset asserted mid-sequence:
  - All state returns to reset values immediately, including a partially filled stack.
  - The first edge after deassertion behaves as a normal cycle.

## Test plan
- Reset then masked update: Z_in..O_in=1111, upd_mask=1010, one edge → {Z,C,N,O}=1010. Then inputs 0000, mask=0000 → flags hold 1010.
- Nested save/restore:
  - Flags 1000, push, then set flags 0110 and push → depth=2.
  - Pop with mask=1111 and inputs 0000 → flags=0110, depth=1.
  - Pop → flags=1000, empty=1.
- Overflow and underflow (DEPTH=4):
  - Five pushes → depth=4, full=1, ovf_err=1, stack contents intact.
  - Five pops → depth=0, unf_err=1 after the fifth.
  - err_clr → both 0.
- Simultaneous push+pop at depth=2 with mask=1111, inputs 0001 → depth stays 2, flags=0001, no error.
- Condition sweep: for flags 0000, 0110, 1000, 0011, check cond 0–15. Example: flags 0011 (N=1,O=1) → GE=1, LT=0, GT=1, LE=0.
- Reset mid-operation:
  - At depth=3 with flags 1111, pulse asyn_n_rst low between edges.
  - Outputs go to 0/empty immediately. A subsequent pop sets unf_err.
